muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the multicycle MIPS core. It implements MULT, MULTU, DIV and DIVU into HI/LO.
- The main control unit launches an operation with Start, then stalls its own state machine on Busy. It resumes when Done pulses.
- One shared WIDTH-bit shift/add-subtract datapath, one bit per cycle. HI/LO are held for later MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  launch request; sampled only in IDLE.
- Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- A  in  WIDTH  rs operand (multiplicand / dividend); sampled with Start.
- B  in  WIDTH  rt operand (multiplier / divisor); sampled with Start.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse; Hi/Lo are valid from this cycle.
- DivZero  out  1  high with Done when a DIV/DIVU had B==0; held until the next Start is accepted.
- Hi  out  WIDTH  HI register (product upper half / remainder).
- Lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE.
  - Busy=0, Done=0, DivZero=0, Hi=0, Lo=0.
  - All internal operand, counter and sign registers cleared; any in-flight operation is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Busy=0, Done=0.
  - On Start=1: latch Op, |A|, |B|, sign flags and bit counter=0; clear DivZero.
  - Absolute values are taken only for signed ops (00, 10); unsigned ops latch A and B raw.
  - Next state: DONE if Op[1]=1 and B==0; otherwise CALC.
- CALC (exactly WIDTH cycles):
  - Busy=1.
  - Multiply: shift-add. Each cycle, if multiplier LSB=1, add multiplicand into the upper half of a 2*WIDTH accumulator, keeping the carry. Then shift the accumulator right 1.
  - Divide: restoring. Each cycle, shift {rem,quot} left 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quot LSB=1.
  - Counter increments each cycle; at counter==WIDTH-1, go to FIX.
- FIX (1 cycle):
  - Busy=1.
  - Apply sign correction, then write Hi/Lo on the exiting edge. Go to DONE.
  - MULT: negate the 2*WIDTH product if sign(A)!=sign(B).
  - DIV: negate the quotient if sign(A)!=sign(B); the remainder takes sign(A).
  - Unsigned ops: no correction.
  - All arithmetic is modulo 2^WIDTH per half, so DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0, with no trap.
- DONE (1 cycle):
  - Done=1, Busy=0. Next state: IDLE.
  - Start is ignored in this state and accepted on the following cycle.
- Divide by zero (DIV/DIVU with B==0):
  - Path is IDLE -> DONE; Busy is never asserted.
  - On the IDLE exit edge: Hi=A (raw), Lo=all ones, DivZero=1.
- Latency, with Start accepted at edge 0:
  - Busy is high in cycles 1..WIDTH+1 (WIDTH CALC cycles plus FIX).
  - Done is high in cycle WIDTH+2 (34 for WIDTH=32).
  - For divide-by-zero, Done is high in cycle 1.
- Start while Busy or Done: ignored. No queuing, no effect on the running operation.
- Hi/Lo change only on the FIX exit edge or the divide-by-zero exit edge. At all other times they hold their last result.
- Outputs Busy/Done are decoded from registered state only, with no combinational path from Start.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles, Done pulse at cycle 34, Hi=0xFFFFFFFE, Lo=0x00000001, DivZero=0.
- MULT A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Repeat with MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=100, B=7 -> Lo=14, Hi=2. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x12345678, B=0 -> Busy never high, Done at cycle 1, DivZero=1, Hi=0x12345678, Lo=0xFFFFFFFF. Next accepted Start clears DivZero.
- Start a MULTU 3*4, pulse Start with a different Op/A/B at cycles 5 and 34 (during Busy and during Done) -> result still Hi=0, Lo=12. A Start at cycle 35 is accepted.
- Assert Reset at cycle 10 of a DIVU, with Hi/Lo holding a prior result -> immediately Busy=0, Done=0, Hi=0, Lo=0, and no Done pulse follows. A new MULTU 6*7 after reset release gives Lo=42.

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer into HI/LO
// One bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_nxt;
  logic                 op_div_q;
  logic                 sign_a_q, sign_b_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     opd_q;
  logic [2*WIDTH-1:0]   acc_q;

  logic                 a_neg, b_neg, div_zero_start;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   div_next;
  logic                 neg_res;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  // Signed ops (Op[0]==0) work on magnitudes; sign is restored in FIX.
  assign a_neg          = ~Op[0] & A[WIDTH-1];
  assign b_neg          = ~Op[0] & B[WIDTH-1];
  assign a_abs          = a_neg ? -A : A;
  assign b_abs          = b_neg ? -B : B;
  assign div_zero_start = Op[1] & (B == '0);

  // acc_q = {running high half, multiplier bits still to consume}
  assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // acc_q = {remainder, quotient}; remainder stays below the divisor.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opd_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  assign neg_res  = sign_a_q ^ sign_b_q;
  assign prod_fix = neg_res  ? -acc_q : acc_q;
  assign quot_fix = neg_res  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_hi   = op_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = op_div_q ? quot_fix : prod_fix[WIDTH-1:0];

  assign Busy = (state == CALC) || (state == FIX);
  assign Done = (state == DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = div_zero_start ? DONE : CALC;
      CALC: if (cnt_q == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      DivZero  <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_div_q <= Op[1];
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            cnt_q    <= '0;
            DivZero  <= div_zero_start;
            if (Op[1]) begin
              opd_q <= b_abs;
              acc_q <= {{WIDTH{1'b0}}, a_abs};
            end else begin
              opd_q <= a_abs;
              acc_q <= {{WIDTH{1'b0}}, b_abs};
            end
            if (div_zero_start) begin
              Hi <= A;
              Lo <= '1;
            end
          end
        end
        CALC: begin
          acc_q <= op_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          Hi <= fix_hi;
          Lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed vector bench for muldiv_seq
module tb_muldiv_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        dz;
    int          busy_n;
    int          done_c;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch at the next negedge; cycle n is the period after edge n-1.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_n, output int done_c,
                        output logic [31:0] hi_1, output logic [31:0] lo_1,
                        output logic dz_1, output logic done_after);
    busy_n = 0;
    done_c = -1;
    done_after = 1'bx;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    hi_1 = Hi; lo_1 = Lo; dz_1 = DivZero;
    for (int c = 1; c <= 100; c++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_c = c;
        break;
      end
      @(negedge Clk);
    end
    @(negedge Clk);
    done_after = Done;
  endtask

  vec_t vecs[10];

  initial begin
    int          busy_n, done_c, c;
    logic [31:0] hi_1, lo_1, prev_hi, prev_lo;
    logic        dz_1, done_after, saw_done;

    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 34};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 34};
    vecs[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 34};
    vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 34};
    vecs[4] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 34};
    vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 34};
    vecs[6] = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 0, 1};
    vecs[7] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 34};
    vecs[8] = '{2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 33, 34};
    vecs[9] = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 0, 1};

    repeat (2) @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_divzero", DivZero, 0);
    chk("reset_hi", Hi, 0);
    chk("reset_lo", Lo, 0);
    Reset = 1'b0;

    prev_hi = '0; prev_lo = '0;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, busy_n, done_c, hi_1, lo_1, dz_1, done_after);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].busy_n);
      chk($sformatf("v%0d_done_cycle", i), done_c, vecs[i].done_c);
      chk($sformatf("v%0d_hi", i), Hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), Lo, vecs[i].lo);
      chk($sformatf("v%0d_divzero", i), DivZero, vecs[i].dz);
      chk($sformatf("v%0d_divzero_cycle1", i), dz_1, vecs[i].dz);
      chk($sformatf("v%0d_done_single", i), done_after, 0);
      if (vecs[i].done_c != 1) begin
        chk($sformatf("v%0d_hi_held", i), hi_1, prev_hi);
        chk($sformatf("v%0d_lo_held", i), lo_1, prev_lo);
      end
      prev_hi = vecs[i].hi; prev_lo = vecs[i].lo;
    end

    // Start pulses during Busy and Done are ignored; cycle 35 Start is taken.
    @(negedge Clk);
    Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd4;
    @(negedge Clk);
    Start = 1'b0;
    done_c = -1;
    for (c = 1; c <= 60; c++) begin
      if (c == 5) begin
        Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7;
      end else if (c == 6) begin
        Start = 1'b0;
      end
      if (Done) begin
        done_c = c;
        break;
      end
      @(negedge Clk);
    end
    chk("ign_done_cycle", done_c, 34);
    Start = 1'b1; Op = 2'b00; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    chk("ign_hi", Hi, 0);
    chk("ign_lo", Lo, 12);
    chk("ign_busy_c35", Busy, 0);
    @(negedge Clk);
    Start = 1'b0;
    chk("c35_accepted", Busy, 1);
    saw_done = 1'b0;
    for (int k = 0; k < 60 && !saw_done; k++) begin
      if (Done) saw_done = 1'b1;
      else @(negedge Clk);
    end
    chk("c35_done_seen", saw_done, 1);
    chk("c35_lo", Lo, 81);
    chk("c35_hi", Hi, 0);

    // Reset mid-divide clears everything and no Done follows.
    @(negedge Clk);
    Start = 1'b1; Op = 2'b11; A = 32'd1000; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_done", Done, 0);
    chk("rst_mid_hi", Hi, 0);
    chk("rst_mid_lo", Lo, 0);
    chk("rst_mid_divzero", DivZero, 0);
    @(negedge Clk);
    Reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done || Busy) saw_done = 1'b1;
    end
    chk("rst_no_activity", saw_done, 0);
    run_op(2'b01, 32'd6, 32'd7, busy_n, done_c, hi_1, lo_1, dz_1, done_after);
    chk("post_rst_done_cycle", done_c, 34);
    chk("post_rst_lo", Lo, 42);
    chk("post_rst_hi", Hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
